// File: rtl/txtbuf_arbiter.sv
// Text-page RAM arbiter: video fetch, page clear and CPU access share one
// single-port RAM with fixed priority vdp > clear > cpu.
module txtbuf_arbiter #(
  parameter logic [15:0] BASE = 16'h0400,
  parameter logic [15:0] LAST = 16'h07F7,
  parameter logic [7:0]  FILL = 8'hA0
) (
  input  logic        CLOCK_50,
  input  logic        reset,
  input  logic        vdp_req,
  input  logic [15:0] vdp_adr,
  output logic [7:0]  vdp_q,
  output logic        vdp_valid,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [15:0] cpu_adr,
  input  logic [7:0]  cpu_wd,
  output logic        cpu_ack,
  output logic [7:0]  cpu_rd,
  input  logic        clr_start,
  output logic        clr_busy,
  output logic [15:0] mem_adr,
  output logic        mem_we,
  output logic [7:0]  mem_wd,
  input  logic [7:0]  mem_q
);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_CLEAR = 1'b1;

  logic [0:0]  state;
  logic [15:0] clr_cnt;
  logic        vdp_pend;
  logic        vdp_pend_hit;
  logic        cpu_pend;
  logic        cpu_pend_rd;
  logic        cpu_pend_hit;

  logic        vdp_hit;
  logic        cpu_in_win;
  logic        clr_take;
  logic        cpu_go;

  // cpu_pend doubles as the ack cycle, so a still-held cpu_req is not re-granted there
  always_comb begin
    vdp_hit    = vdp_req && (vdp_adr >= BASE) && (vdp_adr <= LAST);
    cpu_in_win = (cpu_adr >= BASE) && (cpu_adr <= LAST);
    clr_take   = (state == S_CLEAR) && !vdp_hit;
    cpu_go     = cpu_req && !vdp_hit && !clr_take && !cpu_pend;
  end

  always_comb begin
    mem_adr = '0;
    mem_we  = 1'b0;
    mem_wd  = '0;
    if (!reset) begin
      if (vdp_hit) begin
        mem_adr = vdp_adr;
      end else if (clr_take) begin
        mem_adr = clr_cnt;
        mem_we  = 1'b1;
        mem_wd  = FILL;
      end else if (cpu_go && cpu_in_win) begin
        mem_adr = cpu_adr;
        mem_we  = cpu_we;
        mem_wd  = cpu_wd;
      end
    end
  end

  always_comb begin
    vdp_valid = !reset && vdp_pend;
    vdp_q     = '0;
    if (vdp_valid) vdp_q = vdp_pend_hit ? mem_q : FILL;
    cpu_ack   = !reset && cpu_pend;
    cpu_rd    = '0;
    if (cpu_ack && cpu_pend_rd) cpu_rd = cpu_pend_hit ? mem_q : FILL;
    clr_busy  = !reset && (state == S_CLEAR);
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state        <= S_IDLE;
      clr_cnt      <= BASE;
      vdp_pend     <= 1'b0;
      vdp_pend_hit <= 1'b0;
      cpu_pend     <= 1'b0;
      cpu_pend_rd  <= 1'b0;
      cpu_pend_hit <= 1'b0;
    end else begin
      vdp_pend     <= vdp_req;
      vdp_pend_hit <= vdp_hit;
      cpu_pend     <= cpu_go;
      cpu_pend_rd  <= cpu_go && !cpu_we;
      cpu_pend_hit <= cpu_in_win;
      case (state)
        S_IDLE: begin
          if (clr_start) begin
            state   <= S_CLEAR;
            clr_cnt <= BASE;
          end
        end
        default: begin
          if (clr_take) begin
            if (clr_cnt == LAST) begin
              state   <= S_IDLE;
              clr_cnt <= BASE;
            end else begin
              clr_cnt <= clr_cnt + 16'd1;
            end
          end
        end
      endcase
    end
  end

endmodule
